// File: rtl/karatsuba_pkg.sv
// Shared types and width helpers for the iterative Karatsuba multiplier.
// States are one-hot; width helpers derive half, half+1 and combine widths from W.
package karatsuba_pkg;

    typedef enum logic [5:0] {
        S_IDLE    = 6'b000001,
        S_MUL_HH  = 6'b000010,
        S_MUL_LL  = 6'b000100,
        S_MUL_MID = 6'b001000,
        S_COMBINE = 6'b010000,
        S_DONE    = 6'b100000
    } state_t;

    function automatic int half_w(input int w);
        return w / 2;
    endfunction

    // Half-sums (A_h + A_l) need one extra bit
    function automatic int half_m(input int w);
        return w / 2 + 1;
    endfunction

    function automatic int prod_w(input int w);
        return 2 * w + 2;
    endfunction

endpackage

// File: rtl/karatsuba_mult_half.sv
// Combinational N x N -> 2N unsigned multiplier; the single shared multiplier
// reused for the high, low and middle partial products.
module karatsuba_mult_half #(
    parameter int N = 17
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    assign p = {{N{1'b0}}, a} * {{N{1'b0}}, b};

endmodule

// File: rtl/iterative_karatsuba_nbit.sv
// Iterative W x W -> 2W Karatsuba multiplier: three passes through one (W/2+1)-bit
// multiplier, then a combine step. Optional signed mode via KARATSUBA_SIGNED_EN.
module iterative_karatsuba_nbit
    import karatsuba_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] C
`ifdef KARATSUBA_SIGNED_EN
    ,
    input  logic           is_signed
`endif
);

    localparam int H  = half_w(W);
    localparam int HM = half_m(W);
    localparam int PW = prod_w(W);

    state_t          state, state_nxt;
    logic [W-1:0]    a_q, b_q, a_cap, b_cap;
    logic [2*HM-1:0] p_hh, p_ll, p_m, mul_p;
    logic [HM-1:0]   mul_a, mul_b;
    logic [PW-1:0]   mid;
    logic [2*W-1:0]  c_q, c_sum, c_fin;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (in_valid) state_nxt = S_MUL_HH;
            S_MUL_HH:  state_nxt = S_MUL_LL;
            S_MUL_LL:  state_nxt = S_MUL_MID;
            S_MUL_MID: state_nxt = S_COMBINE;
            S_COMBINE: state_nxt = S_DONE;
            S_DONE:    if (out_ready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign C         = c_q;

    // Operand select for the shared multiplier; zero when idle so it does not toggle
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            S_MUL_HH: begin
                mul_a = {1'b0, a_q[W-1:H]};
                mul_b = {1'b0, b_q[W-1:H]};
            end
            S_MUL_LL: begin
                mul_a = {1'b0, a_q[H-1:0]};
                mul_b = {1'b0, b_q[H-1:0]};
            end
            S_MUL_MID: begin
                mul_a = {1'b0, a_q[W-1:H]} + {1'b0, a_q[H-1:0]};
                mul_b = {1'b0, b_q[W-1:H]} + {1'b0, b_q[H-1:0]};
            end
            default: ;
        endcase
    end

    karatsuba_mult_half #(.N(HM)) u_mult (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    // Middle term is non-negative and below 2^(W+1), so a plain subtract suffices
    assign mid   = PW'(p_m - p_hh - p_ll);
    assign c_sum = (2*W)'((PW'(p_hh) << W) + (mid << H) + PW'(p_ll));

`ifdef KARATSUBA_SIGNED_EN
    logic sign_q;

    // Signed operands are reduced to magnitudes; the sign is reapplied at combine
    assign a_cap = (is_signed && A[W-1]) ? -A : A;
    assign b_cap = (is_signed && B[W-1]) ? -B : B;
    assign c_fin = sign_q ? -c_sum : c_sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sign_q <= 1'b0;
        else if (state == S_IDLE && in_valid)
            sign_q <= is_signed & (A[W-1] ^ B[W-1]);
    end
`else
    assign a_cap = A;
    assign b_cap = B;
    assign c_fin = c_sum;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q  <= '0;
            b_q  <= '0;
            p_hh <= '0;
            p_ll <= '0;
            p_m  <= '0;
            c_q  <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    a_q <= a_cap;
                    b_q <= b_cap;
                end
                S_MUL_HH:  p_hh <= mul_p;
                S_MUL_LL:  p_ll <= mul_p;
                S_MUL_MID: p_m  <= mul_p;
                S_COMBINE: c_q  <= c_fin;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_karatsuba_nbit.sv
// Directed bench for iterative_karatsuba_nbit: W=8/16/32/64 instances share one stimulus;
// checks latency, handshake, backpressure, mid-op reset and products.
module tb_iterative_karatsuba_nbit;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [63:0]  a_in = '0, b_in = '0;
    logic         rdy8, rdy16, rdy32, rdy64;
    logic         vld8, vld16, vld32, vld64;
    logic [15:0]  c8;
    logic [31:0]  c16;
    logic [63:0]  c32;
    logic [127:0] c64;
    logic [3:0]   all_rdy, all_vld;
    int           passed = 0;
    int           total  = 0;
`ifdef KARATSUBA_SIGNED_EN
    logic         is_signed = 1'b0;
`endif

    always #5 clk = ~clk;

    assign all_rdy = {rdy64, rdy32, rdy16, rdy8};
    assign all_vld = {vld64, vld32, vld16, vld8};

    iterative_karatsuba_nbit #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8), .A(a_in[7:0]), .B(b_in[7:0]),
        .out_valid(vld8), .out_ready(out_ready), .C(c8)
`ifdef KARATSUBA_SIGNED_EN
        , .is_signed(is_signed)
`endif
    );
    iterative_karatsuba_nbit #(.W(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16), .A(a_in[15:0]), .B(b_in[15:0]),
        .out_valid(vld16), .out_ready(out_ready), .C(c16)
`ifdef KARATSUBA_SIGNED_EN
        , .is_signed(is_signed)
`endif
    );
    iterative_karatsuba_nbit #(.W(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .A(a_in[31:0]), .B(b_in[31:0]),
        .out_valid(vld32), .out_ready(out_ready), .C(c32)
`ifdef KARATSUBA_SIGNED_EN
        , .is_signed(is_signed)
`endif
    );
    iterative_karatsuba_nbit #(.W(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64), .A(a_in), .B(b_in),
        .out_valid(vld64), .out_ready(out_ready), .C(c64)
`ifdef KARATSUBA_SIGNED_EN
        , .is_signed(is_signed)
`endif
    );

    function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b, input int w);
        logic [127:0] aa, bb, mask;
        mask = (128'd1 << w) - 128'd1;
        aa   = {64'd0, a} & mask;
        bb   = {64'd0, b} & mask;
        return aa * bb;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One full transaction on all instances; C32 is compared with exp32,
    // the other widths with the reference product when chk_all is set.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp32,
                          input string tag, input bit hold, input bit chk_all);
        int lat;
        bit busy_ok, hold_ok;
        lat = 0;
        while (all_rdy != 4'hF && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, " in_ready"}, all_rdy, 4'hF);
        a_in = a; b_in = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0; busy_ok = 1'b1;
        while (all_vld != 4'hF && lat < 10) begin
            if (all_rdy != 4'h0) busy_ok = 1'b0;
            a_in = ~a_in;
            @(posedge clk); #1; lat++;
        end
        check({tag, " latency"}, lat, 4);
        check({tag, " busy"}, {busy_ok, all_rdy}, {1'b1, 4'h0});
        check({tag, " C32"}, c32, exp32);
        if (chk_all) begin
            check({tag, " C8"},  c8,  ref_mul(a, b, 8));
            check({tag, " C16"}, c16, ref_mul(a, b, 16));
            check({tag, " C64"}, c64, ref_mul(a, b, 64));
        end
        if (hold) begin
            hold_ok = 1'b1;
            for (int i = 0; i < 10; i++) begin
                in_valid = (i % 2 == 0);
                a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom};
                @(posedge clk); #1;
                if (all_vld != 4'hF || all_rdy != 4'h0 || c32 !== exp32) hold_ok = 1'b0;
            end
            in_valid = 1'b0;
            check({tag, " hold"}, hold_ok, 1'b1);
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, " release"}, {all_vld, all_rdy}, {4'h0, 4'hF});
    endtask

    initial begin
        logic [63:0] ra, rb;
        #12;
        check("reset vld", all_vld, 4'h0);
        check("reset C", {c64, 16'(c32 | 64'(c16) | 64'(c8))}, 144'd0);
        #5 rst = 1'b1;
        @(posedge clk); #1;
        check("idle ready", all_rdy, 4'hF);

        run_op(64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "ones32", 1'b0, 1'b1);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "ones64", 1'b0, 1'b1);
        run_op(64'h0000_0000_0001_0000, 64'h0000_0000_0001_0000, 64'h0000_0001_0000_0000, "pow16", 1'b0, 1'b1);
        run_op(64'h0, 64'h0000_0000_DEAD_BEEF, 64'h0, "zero", 1'b0, 1'b1);

        out_ready = 1'b0;
        run_op(64'd7, 64'd9, 64'd63, "backpr", 1'b1, 1'b1);

        // Abort while the middle product is being formed
        a_in = 64'hFFFF_FFFF_FFFF_FFFF; b_in = a_in; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort vld", all_vld, 4'h0);
        check("abort C32", c32, 64'h0);
        check("abort C64", c64, 128'h0);
        #2 rst = 1'b1;
        run_op(64'd3, 64'd5, 64'd15, "after_abort", 1'b0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            run_op(ra, rb, 64'(ref_mul(ra, rb, 32)), $sformatf("rand%0d", i), 1'b0, 1'b1);
        end

`ifdef KARATSUBA_SIGNED_EN
        is_signed = 1'b1;
        run_op(64'hFFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, "signed", 1'b0, 1'b0);
        run_op(64'hFFFF_FFFE, 64'hFFFF_FFFD, 64'd6, "signed_nn", 1'b0, 1'b0);
        is_signed = 1'b0;
        run_op(64'hFFFF_FFFE, 64'd3, 64'h2_FFFF_FFFA, "unsigned", 1'b0, 1'b1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
